// File: rtl/xgmii_tx_scheduler.sv
// xgmii_tx_scheduler: turns a 32-bit valid/ready MAC TX frame stream into XGMII column words.
// It inserts start/preamble, terminate and idle characters, holds the minimum inter-packet gap,
// freezes on encoder pause and aborts (error column + o_underrun pulse) frames that underrun.
// Ports: i_clk/i_reset (sync, active-high); i_tx_t* = frame stream in, o_tx_tready = accept;
//        o_xgmii_txd/txc/valid = registered column to encoder; i_xgmii_pause = encoder stall;
//        o_underrun = 1-cycle abort pulse, aligned with the 0xFE error column.
// Build option: define XGMII_TX_SCHED_DIC_EN to enable deficit idle count (d in 0..3).
module xgmii_tx_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int MIN_IPG    = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_tx_tdata,
  input  logic [CTRL_WIDTH-1:0] i_tx_tkeep,
  input  logic                  i_tx_tvalid,
  input  logic                  i_tx_tlast,
  output logic                  o_tx_tready,
  output logic [DATA_WIDTH-1:0] o_xgmii_txd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_txc,
  output logic                  o_xgmii_valid,
  input  logic                  i_xgmii_pause,
  output logic                  o_underrun
);

  localparam logic [31:0] IDLE_WORD  = 32'h07070707;
  localparam logic [31:0] START_WORD = 32'h555555FB;
  localparam logic [31:0] PRE_WORD   = 32'hD5555555;
  localparam logic [31:0] TERM_WORD  = 32'h070707FD;
  localparam logic [31:0] ERR_WORD   = 32'hFEFEFEFE;
  localparam logic [9:0]  IPG_MIN    = 10'(MIN_IPG);

  typedef enum logic [2:0] {ST_IDLE, ST_SOF2, ST_DATA, ST_TERM, ST_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] txd_q, txd_d;
  logic [3:0]  txc_q, txc_d;
  logic [7:0]  ipg_q, ipg_d;
  logic        underrun_q, underrun_d;
  logic        valid_q;
  logic [7:0]  ipg_inc;
  logic        start_ok;

  // c counts idle bytes since the last T character; saturates so long gaps never wrap.
  assign ipg_inc = (ipg_q >= 8'd252) ? 8'd255 : ipg_q + 8'd4;

`ifdef XGMII_TX_SCHED_DIC_EN
  logic [1:0] dic_q, dic_d;
  logic [1:0] dic_start;
  logic [9:0] ipg_need;

  // Start may borrow up to 3 idle bytes; the borrowed amount is carried forward in d
  // so the long-run average gap still meets MIN_IPG.
  always_comb begin
    ipg_need  = {8'd0, dic_q} + IPG_MIN;
    start_ok  = ({2'd0, ipg_q} + 10'd3) >= ipg_need;
    dic_start = ({2'd0, ipg_q} >= ipg_need) ? 2'd0 : 2'(ipg_need - {2'd0, ipg_q});
  end
`else
  assign start_ok = {2'd0, ipg_q} >= IPG_MIN;
`endif

  // Beats are only taken while streaming or draining, never while the encoder is paused.
  assign o_tx_tready = !i_reset && !i_xgmii_pause &&
                       ((state_q == ST_DATA) || (state_q == ST_DROP));

  assign o_xgmii_txd   = txd_q;
  assign o_xgmii_txc   = txc_q;
  assign o_xgmii_valid = valid_q;
  assign o_underrun    = underrun_q;

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    txc_d      = txc_q;
    ipg_d      = ipg_q;
    underrun_d = 1'b0;
`ifdef XGMII_TX_SCHED_DIC_EN
    dic_d      = dic_q;
`endif
    // A paused cycle holds every piece of state, including any pending abort decision.
    if (!i_xgmii_pause) begin
      case (state_q)
        ST_IDLE: begin
          if (i_tx_tvalid && start_ok) begin
            txd_d   = START_WORD;
            txc_d   = 4'b0001;
            state_d = ST_SOF2;
`ifdef XGMII_TX_SCHED_DIC_EN
            dic_d   = dic_start;
`endif
          end else begin
            txd_d = IDLE_WORD;
            txc_d = 4'hF;
            ipg_d = ipg_inc;
          end
        end
        ST_SOF2: begin
          txd_d   = PRE_WORD;
          txc_d   = 4'h0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (!i_tx_tvalid || (!i_tx_tlast && (i_tx_tkeep != 4'hF))) begin
            // Starved source or short non-last beat: poison the frame and drain the rest.
            txd_d      = ERR_WORD;
            txc_d      = 4'hF;
            ipg_d      = 8'd0;
            underrun_d = 1'b1;
            state_d    = (i_tx_tvalid && i_tx_tlast) ? ST_IDLE : ST_DROP;
          end else if (!i_tx_tlast) begin
            txd_d = i_tx_tdata;
            txc_d = 4'h0;
          end else begin
            case (i_tx_tkeep)
              4'hF: begin
                // Full last beat: T goes in the following column.
                txd_d   = i_tx_tdata;
                txc_d   = 4'h0;
                state_d = ST_TERM;
              end
              4'b0001: begin
                txd_d   = {16'h0707, 8'hFD, i_tx_tdata[7:0]};
                txc_d   = 4'b1110;
                ipg_d   = 8'd3;
                state_d = ST_IDLE;
              end
              4'b0011: begin
                txd_d   = {8'h07, 8'hFD, i_tx_tdata[15:0]};
                txc_d   = 4'b1100;
                ipg_d   = 8'd2;
                state_d = ST_IDLE;
              end
              4'b0111: begin
                txd_d   = {8'hFD, i_tx_tdata[23:0]};
                txc_d   = 4'b1000;
                ipg_d   = 8'd1;
                state_d = ST_IDLE;
              end
              default: begin
                // Non-contiguous or empty last-beat keep cannot be encoded: abort.
                txd_d      = ERR_WORD;
                txc_d      = 4'hF;
                ipg_d      = 8'd0;
                underrun_d = 1'b1;
                state_d    = ST_IDLE;
              end
            endcase
          end
        end
        ST_TERM: begin
          txd_d   = TERM_WORD;
          txc_d   = 4'hF;
          ipg_d   = 8'd4;
          state_d = ST_IDLE;
        end
        ST_DROP: begin
          txd_d = IDLE_WORD;
          txc_d = 4'hF;
          ipg_d = ipg_inc;
          if (i_tx_tvalid && i_tx_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      txd_q      <= IDLE_WORD;
      txc_q      <= 4'hF;
      ipg_q      <= 8'd255;
      underrun_q <= 1'b0;
      valid_q    <= 1'b0;
`ifdef XGMII_TX_SCHED_DIC_EN
      dic_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      ipg_q      <= ipg_d;
      underrun_q <= underrun_d;
      // Valid marks a column freshly produced on this edge; paused edges repeat the old one.
      valid_q    <= !i_xgmii_pause;
`ifdef XGMII_TX_SCHED_DIC_EN
      dic_q      <= dic_d;
`endif
    end
  end

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Bench for xgmii_tx_scheduler: frames are generated randomly and the expected stream of
// valid XGMII columns is built from the framing and gap rules, then compared column by column.
module tb_xgmii_tx_scheduler;

  localparam int MIN_IPG = 12;
  localparam logic [35:0] W_IDLE = {32'h07070707, 4'hF};
  localparam logic [35:0] W_S    = {32'h555555FB, 4'h1};
  localparam logic [35:0] W_PRE  = {32'hD5555555, 4'h0};
  localparam logic [35:0] W_TERM = {32'h070707FD, 4'hF};
  localparam logic [35:0] W_ERR  = {32'hFEFEFEFE, 4'hF};

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_tx_tdata = '0;
  logic [3:0]  i_tx_tkeep = 4'hF;
  logic        i_tx_tvalid = 1'b0;
  logic        i_tx_tlast = 1'b0;
  logic        o_tx_tready;
  logic [31:0] o_xgmii_txd;
  logic [3:0]  o_xgmii_txc;
  logic        o_xgmii_valid;
  logic        i_xgmii_pause = 1'b0;
  logic        o_underrun;

  xgmii_tx_scheduler #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .MIN_IPG(MIN_IPG)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_tx_tdata(i_tx_tdata), .i_tx_tkeep(i_tx_tkeep), .i_tx_tvalid(i_tx_tvalid),
    .i_tx_tlast(i_tx_tlast), .o_tx_tready(o_tx_tready),
    .o_xgmii_txd(o_xgmii_txd), .o_xgmii_txc(o_xgmii_txc), .o_xgmii_valid(o_xgmii_valid),
    .i_xgmii_pause(i_xgmii_pause), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];
  int c_m = 255;
  int d_m = 0;
  int exp_und = 0;
  int und_cnt = 0;
  int tready_cnt = 0;
  int idle_run = 0;
  int last_gap = -1;
  int cyc = 0;
  int pause_mode = 0;
  bit mon_en = 0;
  bit synced = 0;
  logic [31:0] frm [0:15];
  logic [35:0] mon_w, mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_start_ok();
`ifdef XGMII_TX_SCHED_DIC_EN
    return (c_m >= MIN_IPG) || (d_m + MIN_IPG - c_m <= 3);
`else
    return c_m >= MIN_IPG;
`endif
  endfunction

  function automatic void model_idle();
    exp_q.push_back(W_IDLE);
    c_m = (c_m + 4 > 255) ? 255 : c_m + 4;
  endfunction

  // Last column holding k data bytes: data lanes, then FD, then 07 fill.
  function automatic logic [35:0] t_word(input logic [31:0] d, input int k);
    logic [31:0] o;
    logic [3:0]  c;
    o = '0;
    c = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < k) begin
        o[8*l +: 8] = d[8*l +: 8];
        c[l] = 1'b0;
      end else if (l == k) begin
        o[8*l +: 8] = 8'hFD;
        c[l] = 1'b1;
      end else begin
        o[8*l +: 8] = 8'h07;
        c[l] = 1'b1;
      end
    end
    return {o, c};
  endfunction

  // ---------------- driver helpers ----------------
  task automatic cycle(input bit force_nopause, output bit hs);
    bit p;
    case (pause_mode)
      1:       p = ($urandom_range(0, 5) == 0);
      2:       p = ((cyc % 32) == 31);
      default: p = 1'b0;
    endcase
    i_xgmii_pause = force_nopause ? 1'b0 : p;
    @(negedge i_clk);
    hs = i_tx_tvalid && o_tx_tready;
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  // ab: 0 clean frame, 1 tvalid dropped one cycle before beat j, 2 tkeep=0011 on beat j.
  task automatic send_frame(input int n, input logic [3:0] lk, input int ab, input int j);
    bit hs;
    int k;
    int waited;
    for (int b = 0; b < n; b++) frm[b] = $urandom;
    while (!model_start_ok()) model_idle();
`ifdef XGMII_TX_SCHED_DIC_EN
    d_m = (d_m + MIN_IPG - c_m > 0) ? d_m + MIN_IPG - c_m : 0;
`endif
    exp_q.push_back(W_S);
    exp_q.push_back(W_PRE);
    if (ab == 0) begin
      for (int b = 0; b < n - 1; b++) exp_q.push_back({frm[b], 4'h0});
      if (lk == 4'hF) begin
        exp_q.push_back({frm[n-1], 4'h0});
        exp_q.push_back(W_TERM);
        c_m = 4;
      end else begin
        k = $countones(lk);
        exp_q.push_back(t_word(frm[n-1], k));
        c_m = 4 - k;
      end
    end else begin
      for (int b = 0; b < j; b++) exp_q.push_back({frm[b], 4'h0});
      exp_q.push_back(W_ERR);
      c_m = 0;
      exp_und++;
      repeat ((ab == 1) ? (n - j) : (n - 1 - j)) model_idle();
    end
    for (int b = 0; b < n; b++) begin
      if (ab == 1 && b == j) begin
        i_tx_tvalid = 1'b0;
        cycle(1'b1, hs);
      end
      i_tx_tvalid = 1'b1;
      i_tx_tdata  = frm[b];
      i_tx_tlast  = (b == n - 1);
      i_tx_tkeep  = (b == n - 1) ? lk : ((ab == 2 && b == j) ? 4'h3 : 4'hF);
      hs = 1'b0;
      waited = 0;
      while (!hs && waited < 200) begin
        cycle(1'b0, hs);
        waited++;
      end
      if (!hs) begin
        check("handshake_timeout", 0, 1);
        break;
      end
    end
    i_tx_tvalid = 1'b0;
    i_tx_tlast  = 1'b0;
  endtask

  // Let the expected stream empty, then leave a long idle gap so the next start is unconstrained.
  task automatic drain();
    bit hs;
    int w;
    w = 0;
    i_tx_tvalid = 1'b0;
    while (exp_q.size() != 0 && w < 600) begin
      cycle(1'b0, hs);
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (8) cycle(1'b1, hs);
    c_m = 255;
    synced = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (o_tx_tready === 1'b1) tready_cnt++;
    if (o_underrun === 1'b1) und_cnt++;
    if (mon_en) begin
      if (i_xgmii_pause) check("tready_in_pause", o_tx_tready, 0);
      if (o_xgmii_valid === 1'b1) begin
        mon_w = {o_xgmii_txd, o_xgmii_txc};
        if (mon_w == W_IDLE) idle_run++;
        else begin
          if (mon_w == W_S) last_gap = idle_run;
          idle_run = 0;
        end
        if (!(synced == 0 && mon_w == W_IDLE)) begin
          synced = 1;
          mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : W_IDLE;
          check("xgmii_word", mon_w, mon_e);
          check("underrun_flag", o_underrun, (mon_e == W_ERR));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hs;
    int n, ab, j, sel;
    logic [3:0] lk;
    logic [3:0] keeps [0:3];
    keeps[0] = 4'h1; keeps[1] = 4'h3; keeps[2] = 4'h7; keeps[3] = 4'hF;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_txd", o_xgmii_txd, 32'h07070707);
    check("rst_txc", o_xgmii_txc, 4'hF);
    check("rst_valid", o_xgmii_valid, 0);
    check("rst_tready", o_tx_tready, 0);
    check("rst_underrun", o_underrun, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    mon_en = 1;

    // 64-byte frame, no pause
    pause_mode = 0;
    tready_cnt = 0;
    send_frame(16, 4'hF, 0, 0);
    drain();
    check("tready_cycles_64B", tready_cnt, 16);

    // same frame shape with pause every 32nd cycle
    pause_mode = 2;
    send_frame(16, 4'hF, 0, 0);
    drain();

    // back-to-back, first ends with one data byte in the last column
    pause_mode = 0;
    send_frame(4, 4'h1, 0, 0);
    send_frame(3, 4'hF, 0, 0);
    drain();
`ifdef XGMII_TX_SCHED_DIC_EN
    check("ipg_after_t1", last_gap, 2);
`else
    check("ipg_after_t1", last_gap, 3);
`endif

    // tvalid dropped mid-frame
    send_frame(8, 4'hF, 1, 6);
    send_frame(2, 4'hF, 0, 0);
    drain();
    check("ipg_after_underrun", last_gap, 3);

    // short keep on non-last beat
    send_frame(6, 4'hF, 2, 2);
    send_frame(2, 4'h7, 0, 0);
    drain();
    check("ipg_after_keep_abort", last_gap, 3);

    // randomized back-to-back traffic with random pause
    pause_mode = 1;
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 12);
      sel = $urandom_range(0, 3);
      lk = keeps[sel];
      ab = (n < 2) ? 0 : (($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
      j = (ab == 1) ? $urandom_range(1, n - 1) : ((ab == 2) ? $urandom_range(0, n - 2) : 0);
      send_frame(n, lk, ab, j);
    end
    drain();

    // reset pulsed in the middle of a frame
    pause_mode = 0;
    mon_en = 0;
    i_tx_tvalid = 1'b1;
    i_tx_tkeep  = 4'hF;
    i_tx_tlast  = 1'b0;
    n = 0;
    j = 0;
    while (n < 3 && j < 50) begin
      i_tx_tdata = $urandom;
      cycle(1'b1, hs);
      if (hs) n++;
      j++;
    end
    check("pre_reset_beats", n, 3);
    i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("midrst_txd", o_xgmii_txd, 32'h07070707);
    check("midrst_txc", o_xgmii_txc, 4'hF);
    check("midrst_valid", o_xgmii_valid, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_tx_tvalid = 1'b0;
    exp_q.delete();
    c_m = 255;
    d_m = 0;
    synced = 0;
    mon_en = 1;
    send_frame(4, 4'h3, 0, 0);
    drain();

    check("underrun_pulses", und_cnt, exp_und);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
